// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: word loads/stores with a fixed access latency,
// raising busy so the upstream pipeline stalls while an access is outstanding.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                op_write_p0;
    logic [ADDR_W-1:0]   idx_p0;
    logic [DATA_W-1:0]   wdata_p0;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                req;
    logic                bad;
    logic                mem_we;
    logic                unused_addr_bits;

    assign req = MemRead | MemWrite;
    assign bad = (MemRead & MemWrite) | (addr[1:0] != 2'b00);

    // Upper address bits alias onto the array; they are intentionally dropped.
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Stall must be visible in the same cycle the request first appears.
    assign busy = ((state == IDLE) & req) | (state == WAIT);

    assign mem_we = (state == WAIT) & req & (cnt == 4'd0) & op_write_p0 & ~reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_p0] <= wdata_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        if (bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= RESP;
                        end else begin
                            op_write_p0 <= MemWrite;
                            idx_p0      <= addr[ADDR_W+1:2];
                            wdata_p0    <= wdata;
                            cnt         <= 4'(LATENCY - 1);
                            state       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A dropped request means the pipeline flushed this access.
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_write_p0) begin
                            rdata <= mem[idx_p0];
                        end
                        done  <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a word-array
// reference model with latency/timing derived from the access rules.
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [31:0]       addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_rdata = '0;

    // Observations from the most recent transaction.
    int          r_busy;
    int          r_done_k;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_start_cyc;
    int          r_done_cyc;
    int          r_done_seen;

    data_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int word_index(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Entered 1 time unit after a rising edge; returns at the same phase.
    // abort_at / reset_at: cycle offset at which the request is dropped or reset pulsed.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int abort_at, input int reset_at);
        r_busy = 0;
        r_done_k = -1;
        r_err = 1'b0;
        r_rdata = '0;
        r_done_seen = 0;
        r_done_cyc = -1;
        MemRead = rd;
        MemWrite = wr;
        addr = a;
        wdata = wd;
        r_start_cyc = cyc;
        for (int k = 0; k < 40; k++) begin
            if (k == abort_at) begin
                MemRead = 1'b0;
                MemWrite = 1'b0;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                MemRead = 1'b0;
                MemWrite = 1'b0;
            end
            #2;
            if (busy) r_busy++;
            if (done) begin
                r_done_seen++;
                r_done_k = k;
                r_err = err;
                r_rdata = rdata;
                r_done_cyc = cyc;
            end
            @(posedge clock);
            #1;
            reset = 1'b0;
            if (r_done_k >= 0) break;
            if ((abort_at >= 0 || reset_at >= 0) && k >= LAT + 4) break;
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Applies the model's view of a completed, accepted access.
    task automatic model_commit(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd);
        if (!((rd && wr) || a[1:0] != 2'b00)) begin
            if (wr) mem_model[word_index(a)] = wd;
            else if (rd) exp_rdata = mem_model[word_index(a)];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_rdata = '0;
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_store_load();
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, -1);
        model_commit(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        vectors++;
        if (r_busy !== LAT + 1) begin miscompares++; $display("FAIL sw_busy_cycles: got %0d expected %0d", r_busy, LAT + 1); end
        vectors++;
        if (r_done_k !== LAT + 1) begin miscompares++; $display("FAIL sw_done_cycle: got %0d expected %0d", r_done_k, LAT + 1); end
        vectors++;
        if (r_err !== 1'b0) begin miscompares++; $display("FAIL sw_err: got %b expected 0", r_err); end
        vectors++;
        if (r_rdata !== exp_rdata) begin miscompares++; $display("FAIL sw_rdata_held: got %h expected %h", r_rdata, exp_rdata); end

        run_access(1'b1, 1'b0, 32'h10, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h10, 32'h0);
        vectors++;
        if (r_busy !== LAT + 1) begin miscompares++; $display("FAIL lw_busy_cycles: got %0d expected %0d", r_busy, LAT + 1); end
        vectors++;
        if (r_done_k !== LAT + 1) begin miscompares++; $display("FAIL lw_done_cycle: got %0d expected %0d", r_done_k, LAT + 1); end
        vectors++;
        if (r_err !== 1'b0) begin miscompares++; $display("FAIL lw_err: got %b expected 0", r_err); end
        vectors++;
        if (r_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata: got %h expected %h", r_rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_back_to_back();
        int sw_done;
        run_access(1'b0, 1'b1, 32'h20, 32'h1234, -1, -1);
        model_commit(1'b0, 1'b1, 32'h20, 32'h1234);
        sw_done = r_done_cyc;
        run_access(1'b1, 1'b0, 32'h20, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h20, 32'h0);
        vectors++;
        if (r_start_cyc !== sw_done + 1) begin miscompares++; $display("FAIL b2b_start: got cycle %0d expected %0d", r_start_cyc, sw_done + 1); end
        vectors++;
        if (r_done_k !== LAT + 1) begin miscompares++; $display("FAIL b2b_done_cycle: got %0d expected %0d", r_done_k, LAT + 1); end
        vectors++;
        if (r_rdata !== 32'h1234) begin miscompares++; $display("FAIL b2b_rdata: got %h expected %h", r_rdata, 32'h1234); end
    endtask

    task automatic test_errors();
        // Misaligned load.
        run_access(1'b1, 1'b0, 32'h13, 32'h0, -1, -1);
        vectors++;
        if (r_busy !== 1) begin miscompares++; $display("FAIL misalign_busy: got %0d expected 1", r_busy); end
        vectors++;
        if (r_done_k !== 1) begin miscompares++; $display("FAIL misalign_done_cycle: got %0d expected 1", r_done_k); end
        vectors++;
        if (r_err !== 1'b1) begin miscompares++; $display("FAIL misalign_err: got %b expected 1", r_err); end
        vectors++;
        if (r_rdata !== exp_rdata) begin miscompares++; $display("FAIL misalign_rdata: got %h expected %h", r_rdata, exp_rdata); end
        // Simultaneous read and write.
        run_access(1'b1, 1'b1, 32'h10, 32'h55555555, -1, -1);
        vectors++;
        if (r_busy !== 1) begin miscompares++; $display("FAIL rdwr_busy: got %0d expected 1", r_busy); end
        vectors++;
        if (r_done_k !== 1) begin miscompares++; $display("FAIL rdwr_done_cycle: got %0d expected 1", r_done_k); end
        vectors++;
        if (r_err !== 1'b1) begin miscompares++; $display("FAIL rdwr_err: got %b expected 1", r_err); end
        vectors++;
        if (r_rdata !== exp_rdata) begin miscompares++; $display("FAIL rdwr_rdata: got %h expected %h", r_rdata, exp_rdata); end
        run_access(1'b1, 1'b0, 32'h10, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h10, 32'h0);
        vectors++;
        if (r_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rdwr_mem_intact: got %h expected %h", r_rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_abort_reset();
        run_access(1'b0, 1'b1, 32'h40, 32'h1111, -1, -1);
        model_commit(1'b0, 1'b1, 32'h40, 32'h1111);
        // Drop the request in the final wait cycle, just before the commit edge.
        run_access(1'b0, 1'b1, 32'h40, 32'hAAAA, LAT, -1);
        vectors++;
        if (r_done_seen !== 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses expected 0", r_done_seen); end
        run_access(1'b1, 1'b0, 32'h40, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h40, 32'h0);
        vectors++;
        if (r_rdata !== 32'h1111) begin miscompares++; $display("FAIL abort_mem: got %h expected %h", r_rdata, 32'h1111); end

        run_access(1'b0, 1'b1, 32'h40, 32'hAAAA, -1, LAT);
        exp_rdata = '0;
        vectors++;
        if (r_done_seen !== 0) begin miscompares++; $display("FAIL rst_mid_done: got %0d pulses expected 0", r_done_seen); end
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rdata: got %h expected %h", rdata, 32'h0); end
        run_access(1'b1, 1'b0, 32'h40, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h40, 32'h0);
        vectors++;
        if (r_rdata !== 32'h1111) begin miscompares++; $display("FAIL rst_mid_mem: got %h expected %h", r_rdata, 32'h1111); end
    endtask

    task automatic test_alias();
        run_access(1'b0, 1'b1, 32'h1000, 32'd5, -1, -1);
        model_commit(1'b0, 1'b1, 32'h1000, 32'd5);
        run_access(1'b1, 1'b0, 32'h0, 32'h0, -1, -1);
        model_commit(1'b1, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (r_rdata !== 32'd5) begin miscompares++; $display("FAIL alias_rdata: got %h expected %h", r_rdata, 32'd5); end
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [31:0] a, wd;
        int          kind, gap;
        bit          is_bad;
        // Seed words 0..15 so every later random load has a known expected value.
        for (int i = 0; i < 16; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2);
            wd = $urandom;
            run_access(1'b0, 1'b1, a, wd, -1, -1);
            model_commit(1'b0, 1'b1, a, wd);
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            wd = $urandom;
            if (kind <= 3) begin
                rd = 1'b0; wr = 1'b1;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            end else if (kind <= 7) begin
                rd = 1'b1; wr = 1'b0;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            end else if (kind == 8) begin
                rd = 1'($urandom_range(0, 1)); wr = ~rd;
                a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end else begin
                rd = 1'b1; wr = 1'b1;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            end
            is_bad = (rd && wr) || (a[1:0] != 2'b00);
            run_access(rd, wr, a, wd, -1, -1);
            model_commit(rd, wr, a, wd);
            vectors++;
            if (r_done_k !== (is_bad ? 1 : LAT + 1)) begin
                miscompares++;
                $display("FAIL rnd_done_cycle[%0d]: got %0d expected %0d", n, r_done_k, is_bad ? 1 : LAT + 1);
            end
            vectors++;
            if (r_busy !== (is_bad ? 1 : LAT + 1)) begin
                miscompares++;
                $display("FAIL rnd_busy[%0d]: got %0d expected %0d", n, r_busy, is_bad ? 1 : LAT + 1);
            end
            vectors++;
            if (r_err !== is_bad) begin
                miscompares++;
                $display("FAIL rnd_err[%0d]: got %b expected %b", n, r_err, is_bad);
            end
            vectors++;
            if (r_rdata !== exp_rdata) begin
                miscompares++;
                $display("FAIL rnd_rdata[%0d]: got %h expected %h (addr %h)", n, r_rdata, exp_rdata, a);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_abort_reset();
        test_alias();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
